// File: rtl/bram_byte_en_requester_pkg.sv
// Shared definitions for the byte-enabled BRAM requester.
// Contents:
//   size_e     - request size codes (byte / half / word / reserved)
//   state_e    - requester FSM state encodings
//   eff_offset - byte-lane offset actually used for a given size
package bram_byte_en_requester_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Halves are forced onto an even lane and words onto lane 0, so low
  // address bits that do not fit the access size are simply ignored.
  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: eff_offset = off;
      SZ_HALF: eff_offset = {off[1], 1'b0};
      default: eff_offset = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/bram_byte_en_requester_load_align_extend.sv
// Combinational load formatter: moves the addressed lane(s) of a BRAM
// word down to bit 0, masks to the access size and sign/zero extends.
// Ports:
//   read_data   in  32  raw BRAM word
//   offset      in  2   byte offset from the request address
//   size        in  2   size code (reserved behaves as word)
//   is_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   rdata       out 32  formatted load result
module load_align_extend
  import bram_byte_en_requester_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = read_data >> {eff_offset(size, offset), 3'b000};
    rdata   = shifted;
    case (size)
      SZ_BYTE: rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/bram_byte_en_requester.sv
// Initiator-side front end for a byte-enabled BRAM. Takes sub-word
// load/store requests from a core, drives the BRAM ports in the accept
// cycle, captures the one-cycle-latency read data and returns formatted
// load data on a valid/ready response channel. One request in flight.
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned halves,
// misaligned words and the reserved size with resp_error and no BRAM access.
// Ports:
//   clock, reset (async, active-high)
//   req_valid/req_ready, req_write, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid/resp_ready, resp_rdata, resp_error
//   bram_readEnable, bram_readAddress, bram_readData
//   bram_writeEnable, bram_writeByteEnable, bram_writeAddress, bram_writeData
module bram_byte_en_requester
  import bram_byte_en_requester_pkg::*;
#(
  parameter int CORE       = 0,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  bram_readEnable,
  output logic [ADDR_WIDTH-1:0] bram_readAddress,
  input  logic [31:0]           bram_readData,
  output logic                  bram_writeEnable,
  output logic [3:0]            bram_writeByteEnable,
  output logic [ADDR_WIDTH-1:0] bram_writeAddress,
  output logic [31:0]           bram_writeData
);

  // Datapath is hard-wired to 32-bit words with four byte lanes.
  generate
    if (DATA_WIDTH != 32 || CORE < 0) begin : g_bad_config
      $error("bram_byte_en_requester: DATA_WIDTH must be 32 and CORE non-negative");
    end
  endgenerate

  state_e      state;
  state_e      state_next;
  logic [1:0]  ld_size;
  logic [1:0]  ld_off;
  logic        ld_unsigned;
  logic [31:0] rdata_q;
  logic        error_q;
  logic [31:0] load_result;
  logic [1:0]  off;
  logic        accept;
  logic        misaligned;
  logic [3:0]  lane_mask;

  assign off    = req_addr[1:0];
  assign accept = (state == ST_IDLE) && req_valid;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = ((req_size == SZ_HALF) && off[0]) ||
                      ((req_size == SZ_WORD) && (off != 2'b00)) ||
                      (req_size == SZ_RSVD);
`else
  assign misaligned = 1'b0;
`endif

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;

  // Next state: rejected requests and stores respond straight away, loads
  // spend one cycle waiting for the BRAM read data.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (misaligned || req_write) state_next = ST_RESP;
          else                         state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: state_next = ST_RESP;
      ST_RESP:    if (resp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // BRAM strobes exist only in the accept cycle; byte enables follow the
  // write strobe so the port is fully quiet otherwise.
  always_comb begin
    bram_readEnable   = accept && !req_write && !misaligned;
    bram_writeEnable  = accept && req_write && !misaligned;
    bram_readAddress  = req_addr[ADDR_WIDTH+1:2];
    bram_writeAddress = req_addr[ADDR_WIDTH+1:2];
    lane_mask         = 4'b1111;
    bram_writeData    = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        lane_mask      = 4'b0001 << off;
        bram_writeData = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        lane_mask      = 4'b0011 << {off[1], 1'b0};
        bram_writeData = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_mask      = 4'b1111;
        bram_writeData = req_wdata;
      end
    endcase
    bram_writeByteEnable = bram_writeEnable ? lane_mask : 4'b0000;
  end

  load_align_extend u_align (
    .read_data   (bram_readData),
    .offset      (ld_off),
    .size        (ld_size),
    .is_unsigned (ld_unsigned),
    .rdata       (load_result)
  );

  // Load attributes are latched at accept because the core may change its
  // request lines while the read is in flight; the result register is
  // cleared at accept so stores and rejected requests return zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ld_size     <= 2'b00;
      ld_off      <= 2'b00;
      ld_unsigned <= 1'b0;
      rdata_q     <= 32'h0;
      error_q     <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        ld_size     <= req_size;
        ld_off      <= off;
        ld_unsigned <= req_unsigned;
        rdata_q     <= 32'h0;
        error_q     <= misaligned;
      end else if (state == ST_RD_WAIT) begin
        rdata_q <= load_result;
      end
    end
  end

endmodule

// File: tb/tb_bram_byte_en_requester.sv
// Testbench for bram_byte_en_requester: fixed vector table, hand-written
// multi-cycle sequences and randomized traffic against a byte-array model.
module tb_bram_byte_en_requester;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        bram_readEnable;
  logic [7:0]  bram_readAddress;
  logic [31:0] bram_readData;
  logic        bram_writeEnable;
  logic [3:0]  bram_writeByteEnable;
  logic [7:0]  bram_writeAddress;
  logic [31:0] bram_writeData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bram_byte_en_requester #(.CORE(0), .ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clock                (clock),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_size             (req_size),
    .req_unsigned         (req_unsigned),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_rdata           (resp_rdata),
    .resp_error           (resp_error),
    .bram_readEnable      (bram_readEnable),
    .bram_readAddress     (bram_readAddress),
    .bram_readData        (bram_readData),
    .bram_writeEnable     (bram_writeEnable),
    .bram_writeByteEnable (bram_writeByteEnable),
    .bram_writeAddress    (bram_writeAddress),
    .bram_writeData       (bram_writeData)
  );

  // Byte-enabled BRAM with one cycle of read latency.
  logic [31:0] bram_mem [256];
  logic [31:0] bram_rd = 32'h0;
  assign bram_readData = bram_rd;

  always @(posedge clock) begin
    if (bram_writeEnable)
      for (int l = 0; l < 4; l++)
        if (bram_writeByteEnable[l]) bram_mem[bram_writeAddress][8*l +: 8] <= bram_writeData[8*l +: 8];
    if (bram_readEnable) bram_rd <= bram_mem[bram_readAddress];
  end

  // Handshake monitor used to measure accept/response cycles.
  int cyc = 0;
  int acc_q[$];
  int rsp_q[$];
  logic [31:0] rsp_data_q[$];

  always @(posedge clock) begin
    if (!reset) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (resp_valid && resp_ready) begin
        rsp_q.push_back(cyc);
        rsp_data_q.push_back(resp_rdata);
      end
    end
    cyc <= cyc + 1;
  end

  // Reference model: flat byte memory, accesses aligned down to their size.
  logic [7:0] ref_mem [1024];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic model_mis(input logic [9:0] a, input logic [1:0] sz);
`ifdef MISALIGN_CHECK_EN
    return (sz == 2'd3) || ((int'(a) % nbytes(sz)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eff_addr(input logic [9:0] a, input logic [1:0] sz);
    int ai = int'(a);
    return ai - (ai % nbytes(sz));
  endfunction

  function automatic logic [31:0] model_load(input logic [9:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v = '0;
    int ea = eff_addr(a, sz);
    int nb = nbytes(sz);
    for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[ea + k];
    if (nb < 4 && !u && v[8*nb-1])
      for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic model_store(input logic [9:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int ea = eff_addr(a, sz);
    for (int k = 0; k < nbytes(sz); k++) ref_mem[ea + k] = wd[8*k +: 8];
  endtask

  function automatic logic [3:0] model_be(input logic [9:0] a, input logic [1:0] sz);
    logic [3:0] r = '0;
    int ea = eff_addr(a, sz);
    for (int k = 0; k < nbytes(sz); k++) r[(ea + k) % 4] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] model_lanes(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r = '0;
    int nb = nbytes(sz);
    for (int l = 0; l < 4; l++) r[8*l +: 8] = wd[8*(l % nb) +: 8];
    return r;
  endfunction

  typedef struct {
    logic        ready;
    logic        re;
    logic        we;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [7:0]  wa;
    logic [7:0]  ra;
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] bwd;
    int          lat;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a
  // rising edge with the response consumed.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic u,
                               input logic [9:0] a, input logic [31:0] wd, output obs_t o);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    o.ready = req_ready;
    o.re    = bram_readEnable;
    o.we    = bram_writeEnable;
    o.be    = bram_writeByteEnable;
    o.bwd   = bram_writeData;
    o.wa    = bram_writeAddress;
    o.ra    = bram_readAddress;
    @(posedge clock); #1;
    req_valid = 1'b0;
    o.lat = 1;
    while (!resp_valid && o.lat < 20) begin
      @(posedge clock); #1;
      o.lat++;
    end
    o.rdata = resp_rdata;
    o.err   = resp_error;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
  endtask

  task automatic checkObs(input string tag, input logic w, input logic [9:0] a, input obs_t o,
                          input logic [31:0] e_rdata, input logic e_err, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input int e_lat);
    checkOutput({tag, "_ready"}, 32'(o.ready), 32'd1);
    checkOutput({tag, "_lat"},   32'(o.lat),   32'(e_lat));
    checkOutput({tag, "_rdata"}, o.rdata,      e_rdata);
    checkOutput({tag, "_err"},   32'(o.err),   32'(e_err));
    checkOutput({tag, "_re"},    32'(o.re),    32'(!w && !e_err));
    checkOutput({tag, "_we"},    32'(o.we),    32'(w && !e_err));
    if (w && !e_err) begin
      checkOutput({tag, "_be"},    32'(o.be), 32'(e_be));
      checkOutput({tag, "_wdata"}, o.bwd,     e_wd);
      checkOutput({tag, "_waddr"}, 32'(o.wa), 32'(a[9:2]));
    end else if (!w && !e_err) begin
      checkOutput({tag, "_raddr"}, 32'(o.ra), 32'(a[9:2]));
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t  vecs[12];
    obs_t  o;
    logic  seen;
    logic  w, u;
    logic [1:0]  sz;
    logic [9:0]  a;
    logic [31:0] wd, e_rdata;
    logic  e_err;

    for (int i = 0; i < 256; i++) bram_mem[i] = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;

    vecs[0]  = '{1'b1, 2'd0, 1'b0, 10'h005, 32'h000000AB, 32'h0, 1'b0, 4'b0010, 32'hABABABAB, 1};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 10'h004, 32'h80FF7F01, 32'h0, 1'b0, 4'b1111, 32'h80FF7F01, 1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 10'h006, 32'h0, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'h0, 2};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 10'h006, 32'h0, 32'h000080FF, 1'b0, 4'b0000, 32'h0, 2};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 10'h004, 32'h0, 32'h00007F01, 1'b0, 4'b0000, 32'h0, 2};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 10'h007, 32'h0, 32'h00000080, 1'b0, 4'b0000, 32'h0, 2};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 10'h007, 32'h0, 32'hFFFFFF80, 1'b0, 4'b0000, 32'h0, 2};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 10'h00A, 32'h1234BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEFBEEF, 1};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 10'h008, 32'h0, 32'hBEEF0000, 1'b0, 4'b0000, 32'h0, 2};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 10'h000, 32'h1234C3A5, 32'h0, 1'b0, 4'b1111, 32'h1234C3A5, 1};
`ifdef MISALIGN_CHECK_EN
    vecs[10] = '{1'b0, 2'd1, 1'b0, 10'h001, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 10'h002, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 1};
`else
    vecs[10] = '{1'b0, 2'd1, 1'b0, 10'h001, 32'h0, 32'hFFFFC3A5, 1'b0, 4'b0000, 32'h0, 2};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 10'h002, 32'h0, 32'h1234C3A5, 1'b0, 4'b0000, 32'h0, 2};
`endif

    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_req_ready",  32'(req_ready),        32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid),       32'd0);
    checkOutput("reset_resp_rdata", resp_rdata,            32'h0);
    checkOutput("reset_resp_error", 32'(resp_error),       32'd0);
    checkOutput("reset_re",         32'(bram_readEnable),  32'd0);
    checkOutput("reset_we",         32'(bram_writeEnable), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, o);
      checkObs($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, o, vecs[i].rdata, vecs[i].err,
               vecs[i].be, vecs[i].bwd, vecs[i].lat);
      if (vecs[i].w && !vecs[i].err) model_store(vecs[i].a, vecs[i].sz, vecs[i].wd);
    end

    $display("[TB] response backpressure");
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h004; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 10 && !resp_valid; n++) begin
      @(posedge clock); #1;
    end
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("hold%0d_valid", n), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("hold%0d_rdata", n), resp_rdata, model_load(10'h004, 2'd2, 1'b0));
      checkOutput($sformatf("hold%0d_ready", n), 32'(req_ready), 32'd0);
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checkOutput("hold_release_ready", 32'(req_ready), 32'd1);

    $display("[TB] back-to-back load then store");
    acc_q.delete(); rsp_q.delete(); rsp_data_q.delete();
    resp_ready = 1'b1;
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h004; req_wdata = '0;
    req_valid = 1'b1;
    for (int n = 0; n < 12 && acc_q.size() < 2; n++) begin
      @(posedge clock); #1;
      if (acc_q.size() == 1) begin
        req_write = 1'b1; req_addr = 10'h040; req_wdata = 32'h13579BDF;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resp_ready = 1'b0;
    checkOutput("b2b_accepts",   32'(acc_q.size()), 32'd2);
    checkOutput("b2b_responses", 32'(rsp_q.size()), 32'd2);
    if (acc_q.size() == 2 && rsp_q.size() == 2) begin
      checkOutput("b2b_accept_gap", 32'(acc_q[1] - acc_q[0]), 32'd3);
      checkOutput("b2b_load_resp",  32'(rsp_q[0] - acc_q[0]), 32'd2);
      checkOutput("b2b_store_resp", 32'(rsp_q[1] - acc_q[0]), 32'd4);
      checkOutput("b2b_load_data",  rsp_data_q[0], model_load(10'h004, 2'd2, 1'b0));
      checkOutput("b2b_store_data", rsp_data_q[1], 32'h0);
    end
    model_store(10'h040, 2'd2, 32'h13579BDF);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h040, 32'h0, o);
    checkObs("b2b_readback", 1'b0, 10'h040, o, 32'h13579BDF, 1'b0, 4'b0, 32'h0, 2);

    $display("[TB] reset during read wait");
    req_write = 1'b0; req_size = 2'd2; req_addr = 10'h004; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clock); #1;
      seen = seen | resp_valid;
    end
    checkOutput("rst_no_resp",   32'(seen),      32'd0);
    checkOutput("rst_rdata",     resp_rdata,     32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 2'd1, 1'b1, 10'h006, 32'h0, o);
    checkObs("rst_next_load", 1'b0, 10'h006, o, model_load(10'h006, 2'd1, 1'b1), 1'b0, 4'b0, 32'h0, 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      a  = 10'($urandom_range(0, 63));
      wd = $urandom;
      e_err   = model_mis(a, sz);
      e_rdata = (w || e_err) ? 32'h0 : model_load(a, sz, u);
      applyStimulus(w, sz, u, a, wd, o);
      checkObs($sformatf("rnd%0d", i), w, a, o, e_rdata, e_err, model_be(a, sz),
               model_lanes(sz, wd), (w || e_err) ? 1 : 2);
      if (w && !e_err) model_store(a, sz, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
